uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Parametrised UART transmit framer that replaces the fixed shift/load controller.
- Owns the state machine, shift register, bit counter and 16x sub-bit counter.
- Generates a configurable frame: start bit, DATA_BITS data bits, optional parity, 1 or 2 stop bits.
- Also drives an IrDA SIR encoded output, a 3/16-bit pulse per zero bit. Sits between the host write interface and the UART/IrDA line drivers.

Parameters:
- DATA_BITS, 8: data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- send  input  1  transmit request, one-cycle pulse or level.
- data  input  DATA_BITS  byte to transmit; sampled only on an accepted send.
- tick16  input  1  one-cycle enable at 16x the baud rate.
- irda_en  input  1  enable IrDA output; sampled only on an accepted send.
- tx  output  1  UART line; idles high.
- irda_tx  output  1  IrDA SIR line; idles low.
- tx_idle  output  1  high while in IDLE.
- done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: tx=1, irda_tx=0, tx_idle=1, done=0. State=IDLE, counters=0.
- Reset mid-frame aborts the frame. tx returns to 1 at the next edge, with no done pulse.

States and transitions:
- IDLE: if send=1, the cycle is the accept cycle.
  - Latch data into the shift register and compute parity from it (even: XOR of bits; odd: inverted).
  - Latch irda_en, clear sub_cnt and bit_cnt, then go to START.
  - tx=0 from the next cycle.
- START: tx=0 for 16 tick16 pulses, then go to DATA.
- DATA: tx = shreg[0]. After 16 ticks, shift right and increment bit_cnt.
  - When bit_cnt reaches DATA_BITS-1 and the 16th tick arrives, go to PARITY if PARITY != 0, else STOP.
- PARITY: tx = parity bit for 16 ticks, then go to STOP.
- STOP: tx=1 for 16*STOP_BITS ticks. On the final tick, pulse done=1 for one cycle and go to IDLE. tx_idle rises in the same cycle as done.

Timing rules:
- sub_cnt is 4 bits. It advances only on cycles with tick16=1 and wraps 15 -> 0, marking the bit boundary.
- Cycles without tick16 hold all state.
- Frame length in bits = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS. Each bit is exactly 16 tick16 pulses.

IrDA output:
- irda_tx=1 iff latched irda_en=1, state != IDLE, current tx bit = 0, and sub_cnt is in 0..2. Stop and idle bits therefore produce no pulse.
- irda_tx is registered so it aligns with tx.

Boundary conditions:
- send while not IDLE is ignored; no queueing.
- send in the same cycle that done pulses is ignored; a new frame may be accepted from the next cycle.
- Changes to data or irda_en mid-frame have no effect.
- tick16 in the accept cycle does not advance sub_cnt.
- Illegal parameter values are rejected by an elaboration-time check.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP (one-hot, 5 bits);
  - parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - SUB_TICKS=16 and IRDA_PULSE_TICKS=3.
- One sub-module, irda_encoder: inputs clock, reset, enable, bit value, sub_cnt; output the registered irda_tx. It is reused later by the receiver loopback path.

Test Plan:
- 8N1 (defaults), tick16 high every cycle, send with data=8'h55 at cycle 0:
  - tx: cycles 1-16 low, then 16-cycle bits 1,0,1,0,1,0,1,0, stop high cycles 145-160;
  - done pulses at cycle 160; tx_idle=0 in cycles 1-159.
- PARITY=1, STOP_BITS=2, data=8'h07, tick16 every 4th cycle:
  - parity bit=1;
  - frame = 12 bits * 64 cycles = 768 cycles to done;
  - tx high for the final 128 cycles.
- irda_en=1, data=8'h00, 8N1, tick16 every cycle:
  - irda_tx high for 3 cycles at the start of the start bit and of each of the 8 data bits (9 pulses total);
  - no pulse in the stop bit; tx behaves as in the plain case.
- send re-asserted at cycles 20 and 100 during an 8'hA5 frame:
  - ignored; exactly one done pulse; transmitted bits match 8'hA5.
- send held high continuously with data=8'h3C:
  - back-to-back frames, each new frame accepted the cycle after done;
  - tx idles exactly one cycle between frames.
- Reset asserted for 1 cycle at cycle 50 of a frame:
  - next cycle tx=1, irda_tx=0, tx_idle=1, done never pulses;
  - a subsequent send transmits a full correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit path and the IrDA encoder.
//   Holds the one-hot framer state encoding, the parity mode codes, the
//   oversampling ratio, the IrDA pulse width in sub-bit ticks, and the
//   parity helper used when a byte is accepted.
package uart_pkg;

  // One-hot state encoding for the transmit framer
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } state_e;

  // Parity mode codes for the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // tick16 pulses per line bit, and IrDA SIR pulse width (3/16 of a bit)
  localparam int SUB_TICKS        = 16;
  localparam int IRDA_PULSE_TICKS = 3;

  // Turns the XOR of the data bits into the transmitted parity bit.
  // Even parity sends the XOR itself; odd parity sends its inverse.
  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/irda_encoder.sv
// irda_encoder
//   Registered IrDA SIR encoder: emits a high pulse during the first
//   IRDA_PULSE_TICKS sub-bit slots of every zero bit while enabled.
//   Inputs are the *next* values of the line bit and sub-bit counter so the
//   registered output lines up with a registered UART line.
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-high reset
//   enable   in   encoder active (IrDA selected and a frame in flight)
//   bit_val  in   UART line value for the coming cycle
//   sub_cnt  in   16x sub-bit position for the coming cycle (4 bits)
//   irda_tx  out  registered IrDA SIR line, idles low
module irda_encoder
  import uart_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       bit_val,
  input  logic [3:0] sub_cnt,
  output logic       irda_tx
);

  logic irda_d;
  logic irda_q;

  // A pulse only for zero bits, and only in the leading 3/16 of the bit
  always_comb begin
    irda_d = enable && !bit_val && (sub_cnt < 4'(IRDA_PULSE_TICKS));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irda_q <= 1'b0;
    end else begin
      irda_q <= irda_d;
    end
  end

  assign irda_tx = irda_q;

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   Parametrised UART transmit framer: start bit, DATA_BITS data bits sent
//   LSB first, optional parity, 1 or 2 stop bits. Each bit lasts 16 tick16
//   pulses. Also drives an IrDA SIR line through irda_encoder.
// Parameters:
//   DATA_BITS  5..9 data bits per frame
//   PARITY     0 none, 1 even, 2 odd
//   STOP_BITS  1 or 2
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-high reset
//   send     in   transmit request (pulse or level), honoured only in IDLE
//   data     in   frame payload, sampled on an accepted send
//   tick16   in   one-cycle enable at 16x baud
//   irda_en  in   IrDA output enable, sampled on an accepted send
//   tx       out  UART line, idles high
//   irda_tx  out  IrDA SIR line, idles low
//   tx_idle  out  high while the framer is idle
//   done     out  one-cycle pulse as the last stop bit completes
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 tick16,
  input  logic                 irda_en,
  output logic                 tx,
  output logic                 irda_tx,
  output logic                 tx_idle,
  output logic                 done
);

  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_tx_framer: illegal DATA_BITS/PARITY/STOP_BITS");
  end

  localparam logic [3:0] SUB_LAST  = 4'(SUB_TICKS - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  state_e               state_q, state_d;
  logic [3:0]           sub_q, sub_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 irda_en_q, irda_en_d;
  logic                 tx_q, tx_d;
  logic                 tx_idle_q, tx_idle_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  // The 16th tick of a bit; sub_cnt wraps 15 -> 0 on this same tick
  assign bit_end = tick16 && (sub_q == SUB_LAST);

  // Next-state logic. bit_cnt counts data bits in DATA and is reused as
  // the stop-bit counter in STOP. The accept cycle clears sub_cnt even if
  // tick16 is high, so the start bit always gets a full 16 ticks.
  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    irda_en_d = irda_en_q;
    done_d    = 1'b0;

    if (state_q != ST_IDLE && tick16) begin
      sub_d = sub_q + 4'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (send) begin
          shreg_d   = data;
          par_d     = parity_bit(^data, PARITY);
          irda_en_d = irda_en;
          sub_d     = '0;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line value is decoded from the next state so the registered tx
  // changes on the same edge as the state it represents.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    tx_idle_d = (state_d == ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sub_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      irda_en_q <= 1'b0;
      tx_q      <= 1'b1;
      tx_idle_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      irda_en_q <= irda_en_d;
      tx_q      <= tx_d;
      tx_idle_q <= tx_idle_d;
      done_q    <= done_d;
    end
  end

  // Fed with next-state values so irda_tx lines up with tx
  irda_encoder u_irda (
    .clock   (clock),
    .reset   (reset),
    .enable  (irda_en_d && (state_d != ST_IDLE)),
    .bit_val (tx_d),
    .sub_cnt (sub_d),
    .irda_tx (irda_tx)
  );

  assign tx      = tx_q;
  assign tx_idle = tx_idle_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer
//   Scoreboard bench for uart_tx_framer. Two instances: 8N1 defaults and an
//   even-parity, two-stop-bit variant. Each accepted send pushes the
//   expected frame; a monitor pops it when tx_idle falls and checks every
//   cycle of the frame, then the done cycle and the idle line.
module tb_uart_tx_framer;

  typedef struct {
    logic [15:0] bits;
    int          len;
    logic        irda;
    int          cycles;
  } frame_t;

  logic       clock;
  logic       reset;
  logic       send0, send1;
  logic [7:0] data;
  logic       tick16;
  logic       irda_en;
  logic       tx0, irda0, idle0, done0;
  logic       tx1, irda1, idle1, done1;
  logic       sel;
  logic       mon_tx, mon_irda, mon_idle, mon_done;

  int         checks;
  int         failures;
  int         frames_done;
  int         done_count;
  int         idle_run;
  int         tick_period;
  bit         check_gap;
  frame_t     exp_q[$];

  uart_tx_framer dut0 (
    .clock   (clock),
    .reset   (reset),
    .send    (send0),
    .data    (data),
    .tick16  (tick16),
    .irda_en (irda_en),
    .tx      (tx0),
    .irda_tx (irda0),
    .tx_idle (idle0),
    .done    (done0)
  );

  uart_tx_framer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clock   (clock),
    .reset   (reset),
    .send    (send1),
    .data    (data),
    .tick16  (tick16),
    .irda_en (irda_en),
    .tx      (tx1),
    .irda_tx (irda1),
    .tx_idle (idle1),
    .done    (done1)
  );

  assign mon_tx   = sel ? tx1   : tx0;
  assign mon_irda = sel ? irda1 : irda0;
  assign mon_idle = sel ? idle1 : idle0;
  assign mon_done = sel ? done1 : done0;

  // 10-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // tick16 changes just after each rising edge so it is stable for the next
  initial begin : tick_gen
    int ph;
    ph     = 0;
    tick16 = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      ph     = (ph + 1) % tick_period;
      tick16 = (ph == 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected line bits: start, data LSB first, optional parity, stop ones
  function automatic frame_t buildFrame(input logic [7:0] d, input int par_mode, input int stops,
                                        input logic irda, input int period);
    frame_t f;
    int     pos;
    int     ones;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    ones      = 0;
    pos       = 1;
    for (int i = 0; i < 8; i++) begin
      f.bits[pos] = d[i];
      ones        = ones + int'(d[i]);
      pos++;
    end
    if (par_mode != 0) begin
      f.bits[pos] = (par_mode == 1) ? ones[0] : ~ones[0];
      pos++;
    end
    f.len    = pos + stops;
    f.irda   = irda;
    f.cycles = f.len * 16 * period;
    return f;
  endfunction

  // One send pulse on an edge that carries a tick, with its expected frame
  task automatic applyStimulus(input int which, input logic [7:0] d, input logic irda);
    int k;
    k = 0;
    @(negedge clock);
    while (!tick16 && k < 16) begin
      @(negedge clock);
      k++;
    end
    data    = d;
    irda_en = irda;
    if (which == 0) send0 = 1'b1;
    else            send1 = 1'b1;
    exp_q.push_back(buildFrame(d, (which == 1) ? 1 : 0, (which == 1) ? 2 : 1, irda, tick_period));
    @(negedge clock);
    send0 = 1'b0;
    send1 = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int budget);
    int k;
    k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    checkOutput("frames_done", frames_done, target);
  endtask

  // Monitor: samples 1 unit after each rising edge
  initial begin : monitor
    int     n;
    int     cyc;
    int     idx;
    logic   t;
    logic   r;
    logic   exp_irda;
    bit     in_frame;
    bit     started;
    frame_t cur;
    in_frame = 0;
    n        = 0;
    cyc      = 0;
    forever begin
      @(posedge clock);
      t = tick16;
      r = reset;
      #1;
      started = 0;
      if (r) begin
        in_frame = 0;
        idle_run = 0;
        checkOutput("rst_tx", mon_tx, 1);
        checkOutput("rst_irda_tx", mon_irda, 0);
        checkOutput("rst_tx_idle", mon_idle, 1);
        checkOutput("rst_done", mon_done, 0);
      end else begin
        if (mon_done) done_count++;
        if (!in_frame && !mon_idle) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_frame", mon_idle, 1);
          end else begin
            cur = exp_q.pop_front();
            if (check_gap) checkOutput("idle_gap", idle_run, 1);
            in_frame = 1;
            started  = 1;
            n        = 0;
            cyc      = 0;
          end
        end
        if (in_frame) begin
          if (!started) begin
            cyc++;
            if (t) n++;
          end
          if (n == 16 * cur.len) begin
            checkOutput("done", mon_done, 1);
            checkOutput("done_tx_idle", mon_idle, 1);
            checkOutput("done_tx", mon_tx, 1);
            checkOutput("done_irda_tx", mon_irda, 0);
            checkOutput("frame_cycles", cyc, cur.cycles);
            in_frame = 0;
            idle_run = 1;
            frames_done++;
          end else begin
            idx      = n / 16;
            exp_irda = cur.irda && (cur.bits[idx] == 1'b0) && ((n % 16) < 3);
            checkOutput("tx", mon_tx, cur.bits[idx]);
            checkOutput("irda_tx", mon_irda, exp_irda);
            checkOutput("busy_tx_idle", mon_idle, 0);
            checkOutput("busy_done", mon_done, 0);
          end
        end else if (mon_idle) begin
          checkOutput("idle_tx", mon_tx, 1);
          checkOutput("idle_irda_tx", mon_irda, 0);
          checkOutput("idle_done", mon_done, 0);
          idle_run++;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    failures++;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    int base;
    checks      = 0;
    failures    = 0;
    frames_done = 0;
    done_count  = 0;
    idle_run    = 0;
    tick_period = 1;
    check_gap   = 0;
    sel         = 1'b0;
    reset       = 1'b1;
    send0       = 1'b0;
    send1       = 1'b0;
    data        = 8'h00;
    irda_en     = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    $display("[TB] 8N1 frame 0x55");
    applyStimulus(0, 8'h55, 1'b0);
    waitFrames(1, 400);

    $display("[TB] IrDA frame 0x00");
    applyStimulus(0, 8'h00, 1'b1);
    waitFrames(2, 400);

    $display("[TB] 0xA5 with ignored sends and mid-frame input changes");
    base = done_count;
    applyStimulus(0, 8'hA5, 1'b0);
    repeat (19) @(negedge clock);
    send0   = 1'b1;
    data    = 8'hFF;
    irda_en = 1'b1;
    @(negedge clock);
    send0 = 1'b0;
    repeat (79) @(negedge clock);
    send0 = 1'b1;
    data  = 8'h00;
    @(negedge clock);
    send0 = 1'b0;
    waitFrames(3, 400);
    repeat (20) @(negedge clock);
    checkOutput("a5_done_pulses", done_count - base, 1);
    checkOutput("a5_queue_left", exp_q.size(), 0);

    $display("[TB] back-to-back 0x3C with send held");
    base    = frames_done;
    data    = 8'h3C;
    irda_en = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(buildFrame(8'h3C, 0, 1, 1'b0, 1));
    @(negedge clock);
    send0 = 1'b1;
    waitFrames(base + 1, 400);
    check_gap = 1;
    waitFrames(base + 3, 800);
    send0 = 1'b0;
    repeat (5) @(negedge clock);
    check_gap = 0;
    checkOutput("b2b_queue_left", exp_q.size(), 0);

    $display("[TB] reset mid-frame, then a full frame");
    base = done_count;
    applyStimulus(0, 8'h00, 1'b1);
    repeat (49) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (200) @(negedge clock);
    checkOutput("rst_no_done", done_count - base, 0);
    base = frames_done;
    applyStimulus(0, 8'hC3, 1'b1);
    waitFrames(base + 1, 400);

    $display("[TB] 8E2 frame 0x07, tick16 every 4th cycle");
    sel         = 1'b1;
    tick_period = 4;
    repeat (8) @(negedge clock);
    base = frames_done;
    applyStimulus(1, 8'h07, 1'b0);
    waitFrames(base + 1, 1200);
    repeat (8) @(negedge clock);
    tick_period = 1;
    sel         = 1'b0;
    repeat (8) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
